// File: rtl/pooling_layer_input_serializer.sv
// Two-bank ping-pong serializer: one KERNEL_SIZE-word row per channel in, one word per cycle out, MSB word first.
// Latency: a row loaded at edge N into an empty serializer presents word 0 in the cycle after edge N.
// Backpressure: out_ready low freezes the current word; in_ready drops only when both banks hold rows (registered, no out_ready path).
module pooling_layer_input_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 2,
    parameter int CHANNELS    = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [CHANNELS*KERNEL_SIZE*DATA_WIDTH-1:0] data_in,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0]           data_out,
    output logic                                     out_last,
    output logic [1:0]                               occupancy
);
    localparam int IDX_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_SIZE - 1);

    // Ping-pong row store; contents are never reset, validity lives in count.
    logic [DATA_WIDTH-1:0] bank [2][CHANNELS][KERNEL_SIZE];

    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [IDX_W-1:0] idx;
    logic             load_fire;
    logic             pop_fire;
    logic             pop_last;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign occupancy = count;

    // A flush cycle discards whatever is presented, so it also blocks the bank write.
    assign load_fire = in_valid && in_ready && !flush;
    assign pop_fire  = out_valid && out_ready;
    assign pop_last  = pop_fire && (idx == LAST_IDX);

    // Capture a whole row into the write bank, reordering so word 0 is the most significant word.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    bank[wr_ptr][c][k] <= data_in[c*KERNEL_SIZE*DATA_WIDTH + (KERNEL_SIZE-k)*DATA_WIDTH - 1 -: DATA_WIDTH];
                end
            end
        end
    end

    // Pointer, word index and row count bookkeeping; flush wins over load and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            idx    <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            idx    <= '0;
        end else begin
            if (load_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fire) begin
                if (pop_last) begin
                    idx    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            // Load and last-word pop in the same cycle cancel out.
            case ({load_fire, pop_last})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Present the current word of every channel; zeros while nothing is buffered.
    always_comb begin
        data_out = '0;
        if (out_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                data_out[c*DATA_WIDTH +: DATA_WIDTH] = bank[rd_ptr][c][idx];
            end
        end
    end

endmodule

// File: tb/tb_pooling_layer_input_serializer.sv
// Directed bench: three serializer instances (K=2 C=2, K=3 C=1, K=4 C=4) on a shared clock and reset.
// Latency: checks sample 1 ns after each rising edge; inputs change at the same point.
// Backpressure: out_ready is held low for several cycles on the K=2 C=2 instance.
module tb_pooling_layer_input_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         flush;
    logic         iv   [3];
    logic         ordy [3];
    logic         irdy [3];
    logic         ovld [3];
    logic         olast[3];
    logic [1:0]   occ  [3];
    logic [127:0] dout [3];

    logic [127:0] din0;
    logic [95:0]  din1;
    logic [511:0] din2;
    logic [63:0]  dout0;
    logic [31:0]  dout1;
    logic [127:0] dout2;

    int KS[3] = '{2, 3, 4};
    int CS[3] = '{2, 1, 4};

    int total = 0;
    int bad   = 0;

    assign dout[0] = {64'b0, dout0};
    assign dout[1] = {96'b0, dout1};
    assign dout[2] = dout2;

    pooling_layer_input_serializer #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .CHANNELS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[0]), .in_ready(irdy[0]), .data_in(din0),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .data_out(dout0),
        .out_last(olast[0]), .occupancy(occ[0]));

    pooling_layer_input_serializer #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[1]), .in_ready(irdy[1]), .data_in(din1),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .data_out(dout1),
        .out_last(olast[1]), .occupancy(occ[1]));

    pooling_layer_input_serializer #(.DATA_WIDTH(32), .KERNEL_SIZE(4), .CHANNELS(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[2]), .in_ready(irdy[2]), .data_in(din2),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .data_out(dout2),
        .out_last(olast[2]), .occupancy(occ[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k of channel c in row r: distinct, incrementing tag.
    function automatic logic [31:0] wd(input int r, input int c, input int k);
        return {8'hA0 + 8'(r), 8'(c), 8'(k), 8'h5A};
    endfunction

    function automatic logic [511:0] mk_row(input int r, input int K, input int C);
        logic [511:0] v;
        v = '0;
        for (int c = 0; c < C; c++)
            for (int k = 0; k < K; k++)
                v[c*K*32 + (K-k)*32 - 1 -: 32] = wd(r, c, k);
        return v;
    endfunction

    function automatic logic [127:0] exp_out(input int r, input int k, input int C);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < C; c++)
            v[c*32 +: 32] = wd(r, c, k);
        return v;
    endfunction

    task automatic set_din(input int d, input logic [511:0] v);
        case (d)
            0:       din0 = v[127:0];
            1:       din1 = v[95:0];
            default: din2 = v;
        endcase
    endtask

    task automatic single_row(input int d, input int r);
        int K;
        int C;
        K = KS[d];
        C = CS[d];
        ordy[d] = 1'b1;
        set_din(d, mk_row(r, K, C));
        iv[d] = 1'b1;
        step();
        iv[d] = 1'b0;
        for (int k = 0; k < K; k++) begin
            chk($sformatf("sr%0d_vld_w%0d", d, k), ovld[d], 1);
            chk($sformatf("sr%0d_dat_w%0d", d, k), dout[d], exp_out(r, k, C));
            chk($sformatf("sr%0d_last_w%0d", d, k), olast[d], (k == K-1));
            chk($sformatf("sr%0d_occ_w%0d", d, k), occ[d], 1);
            step();
        end
        chk($sformatf("sr%0d_vld_end", d), ovld[d], 0);
        chk($sformatf("sr%0d_dat_end", d), dout[d], 0);
        chk($sformatf("sr%0d_occ_end", d), occ[d], 0);
    endtask

    // Offer rows every cycle with out_ready high: the output must be one unbroken word stream in row order.
    task automatic b2b(input int d, input int n, input int base);
        int K;
        int C;
        int r;
        int w;
        logic rdy_pre;
        int rdy_tab[9] = '{1, 0, 1, 0, 1, 0, 1, 1, 1};
        K = KS[d];
        C = CS[d];
        r = 0;
        ordy[d] = 1'b1;
        for (int j = 1; j <= n*K + 1; j++) begin
            iv[d] = (r < n);
            set_din(d, mk_row(base + r, K, C));
            rdy_pre = irdy[d];
            step();
            if (iv[d] && rdy_pre) r++;
            if (j <= n*K) begin
                w = j - 1;
                chk($sformatf("b2b%0d_vld_%0d", d, j), ovld[d], 1);
                chk($sformatf("b2b%0d_dat_%0d", d, j), dout[d], exp_out(base + w/K, w%K, C));
                chk($sformatf("b2b%0d_last_%0d", d, j), olast[d], (w%K == K-1));
            end else begin
                chk($sformatf("b2b%0d_vld_end", d), ovld[d], 0);
            end
            chk($sformatf("b2b%0d_occ_le2_%0d", d, j), (occ[d] != 2'd3), 1);
            if (d == 0 && n == 4 && j <= 9)
                chk($sformatf("b2b0_rdy_%0d", j), irdy[0], rdy_tab[j-1]);
        end
        iv[d] = 1'b0;
        chk($sformatf("b2b%0d_rows", d), r, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        din0 = '0;
        din1 = '0;
        din2 = '0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
        end
        #3;
        chk("rst_rdy", irdy[0], 1);
        chk("rst_vld", ovld[0], 0);
        chk("rst_dat", dout[0], 0);
        chk("rst_last", olast[0], 0);
        chk("rst_occ", occ[0], 0);
        #20;
        rst_n = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_vld_%0d", i), ovld[0], 0);
            chk($sformatf("idle_dat_%0d", i), dout[0], 0);
            chk($sformatf("idle_rdy_%0d", i), irdy[0], 1);
            chk($sformatf("idle_occ_%0d", i), occ[0], 0);
        end

        // Single row with the reference float vector
        din0 = 128'h3F800000_40000000_40400000_40800000;
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        chk("fp_w0_dat", dout[0], 128'h3F800000_40400000);
        chk("fp_w0_last", olast[0], 0);
        chk("fp_w0_vld", ovld[0], 1);
        step();
        chk("fp_w1_dat", dout[0], 128'h40000000_40800000);
        chk("fp_w1_last", olast[0], 1);
        step();
        chk("fp_end_vld", ovld[0], 0);
        chk("fp_end_dat", dout[0], 0);

        single_row(0, 1);
        b2b(0, 4, 2);

        // Backpressure mid-row with both banks full and a third row waiting
        ordy[0] = 1'b1;
        set_din(0, mk_row(20, 2, 2));
        iv[0] = 1'b1;
        step();
        set_din(0, mk_row(21, 2, 2));
        step();
        chk("bp_pre_last", olast[0], 1);
        ordy[0] = 1'b0;
        set_din(0, mk_row(22, 2, 2));
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_dat_%0d", i), dout[0], exp_out(20, 1, 2));
            chk($sformatf("bp_hold_last_%0d", i), olast[0], 1);
            chk($sformatf("bp_hold_rdy_%0d", i), irdy[0], 0);
            chk($sformatf("bp_hold_occ_%0d", i), occ[0], 2);
        end
        ordy[0] = 1'b1;
        step();
        chk("bp_rel_dat0", dout[0], exp_out(21, 0, 2));
        chk("bp_rel_rdy", irdy[0], 1);
        chk("bp_rel_occ", occ[0], 1);
        step();
        iv[0] = 1'b0;
        chk("bp_rel_dat1", dout[0], exp_out(21, 1, 2));
        chk("bp_rel_occ2", occ[0], 2);
        step();
        chk("bp_rel_dat2", dout[0], exp_out(22, 0, 2));
        step();
        chk("bp_rel_dat3", dout[0], exp_out(22, 1, 2));
        chk("bp_rel_last3", olast[0], 1);
        step();
        chk("bp_rel_end", ovld[0], 0);

        // Flush mid-row with a second row queued and a third presented
        set_din(0, mk_row(30, 2, 2));
        iv[0] = 1'b1;
        step();
        set_din(0, mk_row(31, 2, 2));
        step();
        set_din(0, mk_row(32, 2, 2));
        flush = 1'b1;
        step();
        flush = 1'b0;
        iv[0] = 1'b0;
        chk("fl_occ", occ[0], 0);
        chk("fl_vld", ovld[0], 0);
        chk("fl_dat", dout[0], 0);
        chk("fl_rdy", irdy[0], 1);
        // Flush while in_ready is high: the presented row must be dropped
        set_din(0, mk_row(33, 2, 2));
        iv[0] = 1'b1;
        step();
        set_din(0, mk_row(34, 2, 2));
        flush = 1'b1;
        step();
        flush = 1'b0;
        iv[0] = 1'b0;
        chk("fl2_occ", occ[0], 0);
        chk("fl2_vld", ovld[0], 0);
        step();
        chk("fl2_after_vld", ovld[0], 0);
        chk("fl2_after_occ", occ[0], 0);
        single_row(0, 35);

        // Asynchronous reset mid-row, between clock edges
        set_din(0, mk_row(40, 2, 2));
        iv[0] = 1'b1;
        step();
        set_din(0, mk_row(41, 2, 2));
        step();
        iv[0] = 1'b0;
        chk("ar_pre_vld", ovld[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rdy", irdy[0], 1);
        chk("ar_vld", ovld[0], 0);
        chk("ar_dat", dout[0], 0);
        chk("ar_last", olast[0], 0);
        chk("ar_occ", occ[0], 0);
        #10;
        rst_n = 1'b1;
        single_row(0, 42);

        // Width sweep
        single_row(1, 50);
        b2b(1, 3, 60);
        single_row(2, 70);
        b2b(2, 3, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pooling_layer_input_serializer.md
# pooling_layer_input_serializer

Parametrised, double-buffered parallel-to-serial input stage for the pooling layer. Accepts one kernel-row vector of KERNEL_SIZE words per channel from the convolution output stage over a valid/ready handshake. Emits the row one word per cycle, all channels in lockstep, to the pooling comparator. A two-bank ping-pong store lets the next row load while the current one drains; the output stalls under downstream backpressure.

## Interface
- DATA_WIDTH, 32, bits per word (IEEE-754 single in the current build)
- KERNEL_SIZE, 2, words per row vector; legal range 2..16
- CHANNELS, 1, parallel channels sharing one handshake; legal range 1..16
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- flush  input  1  synchronous clear of all buffered rows
- in_valid  input  1  data_in holds a row vector
- in_ready  output  1  serializer can accept a row this cycle
- data_in  input  CHANNELS*KERNEL_SIZE*DATA_WIDTH  row vectors; channel c at bits [(c+1)*K*W-1 : c*K*W]
- out_valid  output  1  data_out holds a valid word
- out_ready  input  1  downstream accepts the word
- data_out  output  CHANNELS*DATA_WIDTH  current word; channel c at bits [(c+1)*W-1 : c*W]
- out_last  output  1  current word is the final word (index KERNEL_SIZE-1) of its row
- occupancy  output  2  rows held: 0, 1 or 2

## Operation
- Storage: bank[2][CHANNELS][KERNEL_SIZE] words. State is wr_ptr (1b), rd_ptr (1b), count (0..2) and word index idx (0..KERNEL_SIZE-1, clog2 width, minimum 1 bit).
- Word order: the most significant word goes out first. Word k of channel c is data_in[c*K*W + (K-k)*W-1 -: W].
- Load fire = in_valid & in_ready. On load fire, bank[wr_ptr] is written with all channels and wr_ptr toggles.
- in_ready = (count != 2). It is registered-state only, with no combinational path from out_ready.
- out_valid = (count != 0). data_out = bank[rd_ptr][c][idx] for every channel c when out_valid, otherwise all zeros.
- out_last = out_valid & (idx == KERNEL_SIZE-1).
- Pop fire = out_valid & out_ready.
  - Not last word: idx increments.
  - Last word: idx clears to 0, rd_ptr toggles and the row is released.
- count update: +1 on load fire only, -1 on last-word pop only, and unchanged when both occur in the same cycle.
- Upstream must hold data_in stable while in_valid is high and in_ready is low. in_valid with in_ready low is a stall, not a drop.
- flush: count, idx, wr_ptr and rd_ptr clear to 0. flush has priority over a simultaneous load or pop, and data presented in that cycle is discarded. Bank contents are not cleared.
- occupancy = count.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, data_out=0, occupancy=0. All pointers and idx are 0. Bank contents are don't-care.
- Reset asserted mid-row drops all rows immediately and asynchronously, with the outputs at their reset values. The first row after release starts at word 0.
- Latency: a row loaded at edge N into an empty serializer gives out_valid=1 with word 0 in the cycle after edge N. This matches the single-cycle load-to-output delay of the previous buffer.
- Throughput: one word per cycle per channel with out_ready held high. Output is gap-free if a new row is offered at least every KERNEL_SIZE cycles.
- Full (count=2): in_ready=0 until the edge that pops a last word. in_ready returns to 1 the following cycle.
- Empty after a last-word pop with no simultaneous load: out_valid=0 and data_out=0 the next cycle.
- Simultaneous load and last-word pop at count=1: the new row is presented the next cycle with idx=0 and no bubble.
- out_ready low holds data_out, idx and out_last stable.

## Test plan
Bench configuration: W=32, K=2, C=2 unless stated.
- **Reset/idle:** release rst_n with in_valid=0 -> out_valid=0, data_out=0, in_ready=1, occupancy=0 for 10 cycles.
- **Single row:** load ch1={0x3F800000,0x40000000} and ch0={0x40400000,0x40800000}, out_ready=1.
  - Cycle 1: data_out={0x3F800000,0x40400000}, out_last=0.
  - Cycle 2: data_out={0x40000000,0x40800000}, out_last=1.
  - Cycle 3: out_valid=0.
- **Back-to-back rows:** offer a row every cycle with out_ready=1 -> in_ready drops after 2 accepted rows. Output is a continuous word stream in row order with no bubble. in_ready pulses high once every 2 cycles.
- **Backpressure:** out_ready=0 for 5 cycles mid-row -> data_out is frozen on word 1, out_last=1, and a third row is refused (in_ready=0). After release, all words arrive in order.
- **Flush/reset mid-op:** flush in the middle of row 1 with row 2 queued and in_valid high -> the next cycle has occupancy=0, out_valid=0, and that cycle's data is discarded. Repeat with an asynchronous rst_n pulse mid-row: outputs go to reset values immediately, without waiting for a clock edge.
- **Width sweep:** rerun the single-row and back-to-back scenarios at K=3,C=1 and K=4,C=4 with incrementing word patterns.
  - Words must come out MSB-word first.
  - out_last must assert on word K-1.
  - occupancy must never exceed 2.
